sync_fifo_banked: RTL and testbench
===================================

# sync_fifo_banked

Single-clock, parametrised FIFO built over `NUM_BANKS` synchronous 1R1W SRAM banks, each with one-cycle registered read latency. It hides that latency behind a two-entry prefetch/skid stage, so reads present first-word-fall-through with full throughput. It also adds occupancy count, almost-full/empty thresholds, synchronous flush and sticky overflow/underflow flags. It sits between stream producers and consumers wherever the data path needs buffering deeper than flops allow.

## Interface
- `DATA_WIDTH`, 8: word width in bits.
- `BANK_DEPTH`, 1024: words per SRAM bank; power of two.
- `NUM_BANKS`, 8: bank count; power of two, ≥1.
- `AFULL_THRESH`, `NUM_BANKS*BANK_DEPTH-4`: `afull` asserts when `count ≥` this value.
- `AEMPTY_THRESH`, 4: `aempty` asserts when `count ≤` this value.
- Derived constants (localparam): `DEPTH = NUM_BANKS*BANK_DEPTH`, `AW = clog2(DEPTH)`, `BW = clog2(BANK_DEPTH)`.

Ports:
- `clk` in 1: single clock; all logic is posedge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous clear of all contents.
- `wr_valid` in 1: push request.
- `wr_ready` out 1: equals `!full`.
- `wr_data` in DATA_WIDTH: push data.
- `rd_valid` out 1: head word present on `rd_data`.
- `rd_ready` in 1: pop when `rd_valid`.
- `rd_data` out DATA_WIDTH: head word, held stable while `rd_valid & !rd_ready`.
- `count` out AW+1: total words held, range 0..DEPTH.
- `full`, `empty`, `afull`, `aempty` out 1 each: status flags.
- `overflow`, `underflow` out 1 each: sticky error flags.

## Operation
- Push fires on `wr_valid & wr_ready`. The word is written to the SRAM at `wptr`; `wptr` increments modulo DEPTH. Bank = `wptr[AW-1:BW]`, row = `wptr[BW-1:0]`. Only the selected bank is write-enabled.
- Pop fires on `rd_valid & rd_ready`. It removes the head of the 2-entry output stage, which shifts the next entry to the head.
- Prefetch issues an SRAM read at `rptr` when all of these hold:
  - `sram_cnt > 0`, counted from registered state, so a word written this cycle is never read this cycle (no read-during-write to the same address);
  - `stage_cnt + inflight - pop < 2`.
- When a read issues, `rptr` increments modulo DEPTH. The bank select is registered alongside `inflight`, and the returning data is muxed from that registered select.
- `count = sram_cnt + inflight + stage_cnt`. It increments on push, decrements on pop, and is unchanged on simultaneous push and pop.
- `full = (count == DEPTH)`, `empty = (count == 0)`. `rd_valid = stage_cnt != 0`, so `rd_valid` may be 0 while `empty = 0` (word in flight).
- `overflow` is set by `wr_valid & full`. `underflow` is set by `rd_ready & !rd_valid & empty`. Both are cleared only by `rst` or `flush`.
- `flush` takes priority over push and pop in the same cycle. Next cycle: pointers, counts, `inflight`, stage and error flags are all 0. Any read in flight is discarded. SRAM contents are not cleared.
- Wrap-around: pointers are AW bits and wrap DEPTH-1→0. The bank index wraps NUM_BANKS-1→0 automatically.

## Timing
- Reset values: `wr_ready`=1, `rd_valid`=0, `rd_data`=0, `count`=0, `empty`=1, `aempty`=1, `full`=0, `afull`=0, `overflow`=0, `underflow`=0.
- Reset asserted mid-operation clears all state immediately (asynchronous); contents are lost.
- Latency, empty FIFO: a word pushed at edge k has its read issued at edge k+1. `rd_valid`=1 with that word after edge k+2.
- Throughput: one push and one pop per cycle sustained indefinitely once `stage_cnt`=2.
- All status flags are registered or derived from registered state only. There is no combinational path from `wr_valid`/`rd_ready` to any output.
- Push at `count = DEPTH-1` makes `full`=1 after that edge. Push and pop in the same cycle while `full` is impossible (`wr_ready`=0); the pop alone gives `full`=0 next cycle.

## Structure
- Package `fifo_pkg` holds:
  - the `clog2` function;
  - the `DEPTH`/`AW` derivation;
  - a `fifo_status_t` struct of the six flags.
- Sub-module `sram_bank_1r1w` provides one bank with a one-cycle registered read. It is a behavioural model for simulation, swappable for the sky130 macro. It is instantiated NUM_BANKS times in a generate loop.
- The top module contains the pointers, counters, prefetch control and 2-entry output stage.

## Test plan
- Reset, then idle → all outputs at reset values; `count`=0.
- DATA_WIDTH=8, BANK_DEPTH=4, NUM_BANKS=2: push 0x11 into the empty FIFO → `rd_valid` rises exactly 2 cycles later with `rd_data`=0x11.
- Same parameters: push 8 words 0x00..0x07 with `rd_ready`=0 → `full`=1, `count`=8. A 9th push raises `overflow`. Then drain all 8 → data returns in order across the bank 0→1 boundary.
- Continuous push and pop with `rd_ready`=1 for 20 cycles → one word per cycle, ordered, pointers wrap twice, `count` stays steady.
- `rd_ready` toggling randomly while the FIFO is half full → `rd_data` holds stable whenever stalled; no loss or duplication.
- `flush` asserted with 5 words stored and a read in flight, with a push in the same cycle → next cycle `count`=0, `empty`=1, `rd_valid`=0, and the pushed word is discarded.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the banked FIFO: size derivation and the status flag bundle.
package fifo_pkg;

  function automatic int clog2(input int value);
    int r;
    for (r = 0; (1 << r) < value; r++) begin
    end
    return r;
  endfunction

  function automatic int fifo_depth(input int num_banks, input int bank_depth);
    return num_banks * bank_depth;
  endfunction

  function automatic int fifo_aw(input int num_banks, input int bank_depth);
    return clog2(fifo_depth(num_banks, bank_depth));
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/sram_bank_1r1w.sv
// One 1R1W SRAM bank with a registered read port; behavioural stand-in for the hard macro.
module sram_bank_1r1w #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_banked.sv
// Banked SRAM FIFO with a two-entry prefetch stage giving first-word-fall-through reads.
module sync_fifo_banked import fifo_pkg::*; #(
  parameter int DATA_WIDTH    = 8,
  parameter int BANK_DEPTH    = 1024,
  parameter int NUM_BANKS     = 8,
  parameter int AFULL_THRESH  = NUM_BANKS * BANK_DEPTH - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      flush,
  input  logic                                      wr_valid,
  output logic                                      wr_ready,
  input  logic [DATA_WIDTH-1:0]                     wr_data,
  output logic                                      rd_valid,
  input  logic                                      rd_ready,
  output logic [DATA_WIDTH-1:0]                     rd_data,
  output logic [fifo_aw(NUM_BANKS, BANK_DEPTH):0]   count,
  output logic                                      full,
  output logic                                      empty,
  output logic                                      afull,
  output logic                                      aempty,
  output logic                                      overflow,
  output logic                                      underflow
);

  localparam int DEPTH = fifo_depth(NUM_BANKS, BANK_DEPTH);
  localparam int AW    = fifo_aw(NUM_BANKS, BANK_DEPTH);
  localparam int BW    = clog2(BANK_DEPTH);
  localparam int RW    = (BW > 0) ? BW : 1;
  localparam int NBW   = (NUM_BANKS > 1) ? clog2(NUM_BANKS) : 1;
  localparam int CW    = AW + 1;

  logic [AW-1:0]         wptr_reg, rptr_reg;
  logic [CW-1:0]         sram_cnt_reg, sram_cnt_next;
  logic                  inflight_reg;
  logic [NBW-1:0]        rd_bank_reg;
  logic [1:0]            stage_cnt_reg, stage_cnt_next;
  logic [DATA_WIDTH-1:0] stage0_reg, stage0_next, stage1_reg, stage1_next;
  logic                  overflow_reg, underflow_reg;

  logic                  push, pop, issue;
  logic [2:0]            occ;
  logic [NBW-1:0]        wr_bank, rd_bank;
  logic [RW-1:0]         wr_row, rd_row;
  logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
  logic [DATA_WIDTH-1:0] ret_word;
  logic [CW-1:0]         count_sum;
  fifo_status_t          status;

  assign count_sum = sram_cnt_reg + CW'(inflight_reg) + CW'(stage_cnt_reg);

  always_comb begin
    status           = '0;
    status.full      = (count_sum == CW'(DEPTH));
    status.empty     = (count_sum == '0);
    status.afull     = (int'(count_sum) >= AFULL_THRESH);
    status.aempty    = (int'(count_sum) <= AEMPTY_THRESH);
    status.overflow  = overflow_reg;
    status.underflow = underflow_reg;
  end

  assign push = wr_valid && !status.full;
  assign pop  = rd_valid && rd_ready;

  // Only words already in SRAM before this edge may be read, so no same-address read/write.
  assign occ   = {1'b0, stage_cnt_reg} + {2'b00, inflight_reg};
  assign issue = (sram_cnt_reg != '0) && (occ < 3'd2 + {2'b00, pop});

  assign wr_bank  = NBW'(wptr_reg >> BW);
  assign rd_bank  = NBW'(rptr_reg >> BW);
  assign wr_row   = RW'(wptr_reg);
  assign rd_row   = RW'(rptr_reg);
  assign ret_word = bank_rdata[rd_bank_reg];

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    sram_bank_1r1w #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (BANK_DEPTH),
      .ADDR_WIDTH (RW)
    ) u_bank (
      .clk   (clk),
      .we    (push && (wr_bank == NBW'(gi))),
      .waddr (wr_row),
      .wdata (wr_data),
      .re    (issue && (rd_bank == NBW'(gi))),
      .raddr (rd_row),
      .rdata (bank_rdata[gi])
    );
  end

  always_comb begin
    sram_cnt_next = sram_cnt_reg;
    case ({push, issue})
      2'b10:   sram_cnt_next = sram_cnt_reg + CW'(1);
      2'b01:   sram_cnt_next = sram_cnt_reg - CW'(1);
      default: sram_cnt_next = sram_cnt_reg;
    endcase
  end

  // Pop shifts the stage first; a returning read then lands in the first free slot.
  always_comb begin
    stage_cnt_next = stage_cnt_reg;
    stage0_next    = stage0_reg;
    stage1_next    = stage1_reg;
    if (pop) begin
      stage0_next    = stage1_reg;
      stage_cnt_next = stage_cnt_reg - 2'd1;
    end
    if (inflight_reg) begin
      if (stage_cnt_next == 2'd0) stage0_next = ret_word;
      else                        stage1_next = ret_word;
      stage_cnt_next = stage_cnt_next + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      sram_cnt_reg  <= '0;
      inflight_reg  <= 1'b0;
      rd_bank_reg   <= '0;
      stage_cnt_reg <= '0;
      stage0_reg    <= '0;
      stage1_reg    <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (flush) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      sram_cnt_reg  <= '0;
      inflight_reg  <= 1'b0;
      rd_bank_reg   <= '0;
      stage_cnt_reg <= '0;
      stage0_reg    <= '0;
      stage1_reg    <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (push)  wptr_reg <= wptr_reg + AW'(1);
      if (issue) begin
        rptr_reg    <= rptr_reg + AW'(1);
        rd_bank_reg <= rd_bank;
      end
      inflight_reg  <= issue;
      sram_cnt_reg  <= sram_cnt_next;
      stage_cnt_reg <= stage_cnt_next;
      stage0_reg    <= stage0_next;
      stage1_reg    <= stage1_next;
      if (wr_valid && status.full)                 overflow_reg  <= 1'b1;
      if (rd_ready && !rd_valid && status.empty)   underflow_reg <= 1'b1;
    end
  end

  assign wr_ready  = !status.full;
  assign rd_valid  = (stage_cnt_reg != 2'd0);
  assign rd_data   = stage0_reg;
  assign count     = count_sum;
  assign full      = status.full;
  assign empty     = status.empty;
  assign afull     = status.afull;
  assign aempty    = status.aempty;
  assign overflow  = status.overflow;
  assign underflow = status.underflow;

endmodule

// File: tb/tb_sync_fifo_banked.sv
// Random and directed stimulus against a queue model of the banked FIFO (8 words, 2 banks of 4).
module tb_sync_fifo_banked;

  localparam int DW     = 8;
  localparam int BD     = 4;
  localparam int NB     = 2;
  localparam int DEPTH  = NB * BD;
  localparam int AFT    = 6;
  localparam int AET    = 2;

  logic          clk = 1'b0;
  logic          rst, flush, wr_valid, rd_ready;
  logic [DW-1:0] wr_data;
  logic          wr_ready, rd_valid, full, empty, afull, aempty, overflow, underflow;
  logic [DW-1:0] rd_data;
  logic [3:0]    count;

  sync_fifo_banked #(
    .DATA_WIDTH    (DW),
    .BANK_DEPTH    (BD),
    .NUM_BANKS     (NB),
    .AFULL_THRESH  (AFT),
    .AEMPTY_THRESH (AET)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .afull     (afull),
    .aempty    (aempty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  // Each word remembers the edge it was pushed on; it must surface exactly two edges later
  // or as soon as it reaches the head, whichever is later.
  typedef struct {
    logic [DW-1:0] data;
    int            t;
  } entry_t;

  entry_t q[$];
  logic   m_ovf, m_unf;
  int     cyc;
  int     n_checks;
  int     n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_outputs(output logic exp_valid);
    int sz;
    sz = q.size();
    exp_valid = 1'b0;
    if (sz > 0) exp_valid = (q[0].t + 2 <= cyc);
    check("count",     32'(count),     32'(sz));
    check("full",      32'(full),      32'(sz == DEPTH));
    check("wr_ready",  32'(wr_ready),  32'(sz != DEPTH));
    check("empty",     32'(empty),     32'(sz == 0));
    check("afull",     32'(afull),     32'(sz >= AFT));
    check("aempty",    32'(aempty),    32'(sz <= AET));
    check("overflow",  32'(overflow),  32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_unf));
    check("rd_valid",  32'(rd_valid),  32'(exp_valid));
    if (exp_valid) check("rd_data", 32'(rd_data), 32'(q[0].data));
  endtask

  task automatic cycle(input logic wv, input logic [DW-1:0] wd, input logic rr, input logic fl);
    logic exp_valid;
    int   sz;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    flush    = fl;
    check_outputs(exp_valid);
    sz = q.size();
    if (fl) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (wv && sz == DEPTH)           m_ovf = 1'b1;
      if (rr && !exp_valid && sz == 0) m_unf = 1'b1;
      if (exp_valid && rr) begin
        $display("pop  data=%02h cycle=%0d", q[0].data, cyc);
        q.delete(0);
      end
      if (wv && sz < DEPTH) begin
        $display("push data=%02h cycle=%0d", wd, cyc);
        q.push_back('{data: wd, t: cyc + 1});
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic async_reset();
    logic dummy;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    flush    = 1'b0;
    #2 rst = 1'b1;
    #1;
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check_outputs(dummy);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic dummy;
    int   wprob;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    rst      = 1'b1;
    flush    = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    wr_data  = '0;

    repeat (3) @(posedge clk);
    #1;
    check_outputs(dummy);
    check("rd_data_rst", 32'(rd_data), 32'h0);
    rst = 1'b0;
    repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Single word into an empty FIFO: visible exactly two edges after the push.
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Fill to full, overflow on the ninth push, then drain across the bank boundary.
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (12) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Streaming: push and pop every cycle, pointers wrap repeatedly.
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
    repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Half full with a stuttering consumer.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    for (int i = 0; i < 60; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);

    // Flush with five words stored, a read in flight and a concurrent push.
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 8'hAA, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic with varying load and occasional flushes.
    for (int seg = 0; seg < 3; seg++) begin
      wprob = (seg == 0) ? 75 : (seg == 1) ? 50 : 30;
      for (int i = 0; i < 150; i++)
        cycle(1'($urandom_range(0, 99) < wprob), 8'($urandom),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 63) == 0));
    end

    // Asynchronous reset in the middle of traffic.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0);
    async_reset();
    for (int i = 0; i < 30; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    repeat (12) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
